hwag_tooth_sync: RTL and testbench

- Consumes the single-cycle filtered edge strobe from the crank-input capture stage.
- Measures each tooth period in timebase ticks and detects the missing-tooth gap (default 60-2 wheel, 58 real teeth).
- Verifies one full revolution before asserting sync, then tracks tooth number.
- Feeds the angle generator with tooth number, last period and sync status.

---
 rtl/hwag_pkg.sv | 11 +
 rtl/hwag_period_hist.sv | 62 ++++++
 rtl/hwag_tooth_sync.sv | 103 ++++++++++
 tb/tb_hwag_tooth_sync.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_pkg.sv
// Shared state type and default wheel constants for the crank tooth synchroniser.
package hwag_pkg;

    typedef enum logic [1:0] {SEARCH, VERIFY, SYNCED} hwag_state_t;

    localparam int unsigned DEF_TEETH  = 58;
    localparam int unsigned DEF_TCNT_W = 6;
    localparam int unsigned DEF_WIDTH  = 24;
    localparam int unsigned GAP_RATIO  = 2;

endpackage

// File: rtl/hwag_period_hist.sv
// Saturating tooth-period counter, three-deep period history and gap detector.
module hwag_period_hist
    import hwag_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             edge_in,
    input  logic             resync,
    output logic [WIDTH-1:0] period,
    output logic             gap,
    output logic             stall_evt
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hist [3];
    logic [1:0]       vcnt;
    logic             edge_acc;
    logic [WIDTH:0]   thresh;

    // resync swallows a coincident edge; the counter keeps running through it
    assign edge_acc  = edge_in && !resync;
    assign stall_evt = ena && !resync && !edge_acc && (cnt == CNT_MAX - 1'b1);
    assign period    = cnt;
    assign thresh    = (WIDTH+1)'(GAP_RATIO) * {1'b0, hist[0]};
    assign gap       = edge_acc && (vcnt != 2'd0) && (hist[0] != '0) && ({1'b0, cnt} > thresh);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
            vcnt    <= 2'd0;
        end else begin
            if (edge_acc) begin
                cnt <= {{(WIDTH-1){1'b0}}, ena};
            end else if (ena && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (resync || stall_evt) begin
                hist[0] <= '0;
                hist[1] <= '0;
                hist[2] <= '0;
                vcnt    <= 2'd0;
            end else if (edge_acc) begin
                hist[2] <= hist[1];
                hist[1] <= hist[0];
                hist[0] <= cnt;
                if (vcnt != 2'd2) begin
                    vcnt <= vcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hwag_tooth_sync.sv
// Missing-tooth wheel synchroniser: verifies a full revolution, then tracks tooth number.
module hwag_tooth_sync
    import hwag_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned TEETH  = DEF_TEETH,
    parameter int unsigned TCNT_W = DEF_TCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              edge_in,
    input  logic              resync,
    output logic              sync,
    output logic [TCNT_W-1:0] tooth_num,
    output logic              tooth_stb,
    output logic              gap_stb,
    output logic [WIDTH-1:0]  period_last,
    output logic              sync_err,
    output logic              stall
);

    localparam logic [TCNT_W-1:0] LAST_TOOTH = TCNT_W'(TEETH - 1);

    hwag_state_t      state;
    logic [WIDTH-1:0] period;
    logic             gap;
    logic             stall_evt;
    logic             last;

    hwag_period_hist #(
        .WIDTH(WIDTH)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .edge_in  (edge_in),
        .resync   (resync),
        .period   (period),
        .gap      (gap),
        .stall_evt(stall_evt)
    );

    assign last = (tooth_num == LAST_TOOTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            sync        <= 1'b0;
            tooth_num   <= '0;
            tooth_stb   <= 1'b0;
            gap_stb     <= 1'b0;
            period_last <= '0;
            sync_err    <= 1'b0;
            stall       <= 1'b0;
        end else begin
            tooth_stb <= 1'b0;
            gap_stb   <= 1'b0;
            sync_err  <= 1'b0;
            stall     <= 1'b0;
            if (resync) begin
                state     <= SEARCH;
                sync      <= 1'b0;
                tooth_num <= '0;
            end else if (stall_evt) begin
                state     <= SEARCH;
                sync      <= 1'b0;
                tooth_num <= '0;
                stall     <= 1'b1;
            end else if (edge_in) begin
                tooth_stb   <= 1'b1;
                period_last <= period;
                case (state)
                    SEARCH: begin
                        tooth_num <= '0;
                        if (gap) begin
                            state   <= VERIFY;
                            gap_stb <= 1'b1;
                        end
                    end
                    VERIFY, SYNCED: begin
                        if (gap && last) begin
                            state     <= SYNCED;
                            sync      <= 1'b1;
                            tooth_num <= '0;
                            gap_stb   <= 1'b1;
                        end else if (gap || last) begin
                            // early gap or missing gap: restart the search from scratch
                            state     <= SEARCH;
                            sync      <= 1'b0;
                            tooth_num <= '0;
                            sync_err  <= 1'b1;
                        end else begin
                            tooth_num <= tooth_num + 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Self-checking bench: directed wheel scenarios plus randomized teeth against a period-level model.
module tb_hwag_tooth_sync;

    localparam int     W      = 24;
    localparam int     TEETH  = 58;
    localparam longint MAXC   = (64'd1 << W) - 1;
    localparam int     M_SRCH = 0;
    localparam int     M_VRFY = 1;
    localparam int     M_SYNC = 2;

    logic clk = 1'b0, rst = 1'b0, ena = 1'b0, edge_in = 1'b0, resync = 1'b0;
    logic         sync, tooth_stb, gap_stb, sync_err, stall;
    logic [5:0]   tooth_num;
    logic [W-1:0] period_last;

    logic s_ena = 1'b0, s_edge = 1'b0, s_resync = 1'b0;
    logic       s_sync, s_tooth_stb, s_gap_stb, s_sync_err, s_stall;
    logic [5:0] s_tooth_num;
    logic [7:0] s_period_last;

    int checks = 0;
    int fails  = 0;

    // reference model state: periods in ticks, wheel phase as plain integers
    longint m_cnt, m_prev, m_plast;
    int     m_valid, m_state, m_tooth;
    bit     m_sync, m_tstb, m_gstb, m_err, m_stall;

    always #5 clk = ~clk;

    hwag_tooth_sync #(.WIDTH(W), .TEETH(TEETH), .TCNT_W(6)) dut (
        .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in), .resync(resync),
        .sync(sync), .tooth_num(tooth_num), .tooth_stb(tooth_stb), .gap_stb(gap_stb),
        .period_last(period_last), .sync_err(sync_err), .stall(stall)
    );

    hwag_tooth_sync #(.WIDTH(8), .TEETH(TEETH), .TCNT_W(6)) dut_s (
        .clk(clk), .rst(rst), .ena(s_ena), .edge_in(s_edge), .resync(s_resync),
        .sync(s_sync), .tooth_num(s_tooth_num), .tooth_stb(s_tooth_stb), .gap_stb(s_gap_stb),
        .period_last(s_period_last), .sync_err(s_sync_err), .stall(s_stall)
    );

    function automatic logic [34:0] obs();
        return {sync, tooth_num, tooth_stb, gap_stb, period_last, sync_err, stall};
    endfunction

    function automatic logic [34:0] expv();
        return {m_sync, 6'(m_tooth), m_tstb, m_gstb, 24'(m_plast), m_err, m_stall};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_prev = 0; m_plast = 0; m_valid = 0; m_state = M_SRCH; m_tooth = 0;
        m_sync = 0; m_tstb = 0; m_gstb = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic model_lose();
        m_state = M_SRCH; m_sync = 0; m_tooth = 0; m_prev = 0; m_valid = 0;
    endtask

    task automatic model_tick(input bit e, input bit ed, input bit rs);
        longint newp;
        bit     gap;
        m_tstb = 0; m_gstb = 0; m_err = 0; m_stall = 0;
        if (rs) begin
            model_lose();
            if (e && m_cnt < MAXC) m_cnt++;
        end else if (ed) begin
            newp    = m_cnt;
            m_cnt   = e ? 1 : 0;
            gap     = (m_valid > 0) && (m_prev != 0) && (newp > 2 * m_prev);
            m_prev  = newp;
            m_valid = (m_valid < 2) ? m_valid + 1 : 2;
            m_tstb  = 1;
            m_plast = newp;
            if (m_state == M_SRCH) begin
                m_tooth = 0;
                if (gap) begin m_state = M_VRFY; m_gstb = 1; end
            end else if (gap && m_tooth == TEETH - 1) begin
                m_state = M_SYNC; m_sync = 1; m_tooth = 0; m_gstb = 1;
            end else if (gap || m_tooth == TEETH - 1) begin
                m_err = 1; model_lose();
            end else begin
                m_tooth++;
            end
        end else if (e && m_cnt < MAXC) begin
            m_cnt++;
            if (m_cnt == MAXC) begin m_stall = 1; model_lose(); end
        end
    endtask

    task automatic step(input bit e, input bit ed, input bit rs);
        ena = e; edge_in = ed; resync = rs;
        @(posedge clk);
        model_tick(e, ed, rs);
        #1;
        ena = 0; edge_in = 0; resync = 0;
    endtask

    // one tooth whose period is n ticks with ena held high
    task automatic tooth(input int n);
        for (int i = 1; i < n; i++) step(1, 0, 0);
        step(1, 1, 0);
    endtask

    task automatic acquire();
        tooth(100);
        tooth(300);
        repeat (TEETH - 1) tooth(100);
        tooth(300);
    endtask

    task automatic s_step(input bit ed);
        s_ena = 1; s_edge = ed;
        @(posedge clk);
        model_tick(0, 0, 0);
        #1;
        s_edge = 0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== '0) begin
            fails++; $display("FAIL reset_main: got %h want 0", obs());
        end
        checks++;
        if ({s_sync, s_tooth_num, s_tooth_stb, s_gap_stb, s_period_last, s_sync_err, s_stall} !== '0)
        begin
            fails++; $display("FAIL reset_small: sync=%b tooth=%0d plast=%0d", s_sync, s_tooth_num,
                              s_period_last);
        end
        rst = 1;
    endtask

    task automatic test_sync_acquire();
        for (int k = 0; k < 3 + 1 + (TEETH - 1) + 1; k++) begin
            if (k == 3 || k == TEETH + 3) tooth(300);
            else tooth(100);
            checks++;
            if (obs() !== expv()) begin
                fails++; $display("FAIL acquire_edge%0d: got %h want %h", k, obs(), expv());
            end
            if (k == 3) begin
                checks++;
                if (gap_stb !== 1'b1 || sync !== 1'b0) begin
                    fails++; $display("FAIL first_gap: gap_stb=%b sync=%b want 1 0", gap_stb, sync);
                end
            end
            if (k == TEETH + 2) begin
                checks++;
                if (tooth_num !== 6'd57) begin
                    fails++; $display("FAIL verify_count: tooth_num=%0d want 57", tooth_num);
                end
            end
        end
        checks++;
        if (sync !== 1'b1 || tooth_num !== 6'd0 || period_last !== 24'd300 || gap_stb !== 1'b1) begin
            fails++; $display("FAIL sync_gain: sync=%b tooth=%0d plast=%0d gap_stb=%b want 1 0 300 1",
                              sync, tooth_num, period_last, gap_stb);
        end
    endtask

    task automatic test_early_gap();
        repeat (40) tooth(100);
        checks++;
        if (tooth_num !== 6'd40 || sync !== 1'b1) begin
            fails++; $display("FAIL tooth40: tooth=%0d sync=%b want 40 1", tooth_num, sync);
        end
        tooth(300);
        checks++;
        if (sync_err !== 1'b1 || sync !== 1'b0 || tooth_num !== 6'd0 || gap_stb !== 1'b0) begin
            fails++; $display("FAIL early_gap: err=%b sync=%b tooth=%0d gap_stb=%b want 1 0 0 0",
                              sync_err, sync, tooth_num, gap_stb);
        end
        checks++;
        if (obs() !== expv()) begin
            fails++; $display("FAIL early_gap_vec: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_gap_boundary();
        tooth(100);
        tooth(100);
        tooth(200);
        checks++;
        if (gap_stb !== 1'b0 || period_last !== 24'd200) begin
            fails++; $display("FAIL ratio_equal: gap_stb=%b plast=%0d want 0 200", gap_stb, period_last);
        end
        tooth(100);
        tooth(201);
        checks++;
        if (gap_stb !== 1'b1 || sync_err !== 1'b0) begin
            fails++; $display("FAIL ratio_above: gap_stb=%b err=%b want 1 0", gap_stb, sync_err);
        end
    endtask

    task automatic test_missing_gap();
        repeat (TEETH - 1) tooth(100);
        tooth(300);
        checks++;
        if (sync !== 1'b1 || obs() !== expv()) begin
            fails++; $display("FAIL resync_gain: got %h want %h", obs(), expv());
        end
        repeat (TEETH - 1) tooth(100);
        tooth(100);
        checks++;
        if (sync_err !== 1'b1 || sync !== 1'b0 || gap_stb !== 1'b0 || tooth_num !== 6'd0) begin
            fails++; $display("FAIL missing_gap: err=%b sync=%b gap_stb=%b tooth=%0d want 1 0 0 0",
                              sync_err, sync, gap_stb, tooth_num);
        end
    endtask

    task automatic test_resync();
        acquire();
        repeat (5) tooth(100);
        checks++;
        if (sync !== 1'b1 || tooth_num !== 6'd5) begin
            fails++; $display("FAIL pre_resync: sync=%b tooth=%0d want 1 5", sync, tooth_num);
        end
        for (int i = 1; i < 100; i++) step(1, 0, 0);
        step(1, 1, 1);
        checks++;
        if (sync !== 1'b0 || tooth_stb !== 1'b0 || sync_err !== 1'b0 || tooth_num !== 6'd0) begin
            fails++; $display("FAIL resync_edge: sync=%b tstb=%b err=%b tooth=%0d want 0 0 0 0",
                              sync, tooth_stb, sync_err, tooth_num);
        end
        tooth(100);
        checks++;
        if (period_last !== 24'd200 || gap_stb !== 1'b0 || tooth_stb !== 1'b1) begin
            fails++; $display("FAIL resync_count: plast=%0d gap_stb=%b tstb=%b want 200 0 1",
                              period_last, gap_stb, tooth_stb);
        end
    endtask

    task automatic test_async_reset();
        acquire();
        repeat (23) tooth(100);
        checks++;
        if (sync !== 1'b1 || tooth_num !== 6'd23 || obs() !== expv()) begin
            fails++; $display("FAIL pre_reset: got %h want %h", obs(), expv());
        end
        #2 rst = 0;
        #1;
        checks++;
        if (obs() !== '0) begin
            fails++; $display("FAIL async_reset: got %h want 0", obs());
        end
        model_reset();
        #1 rst = 1;
        tooth(301);
        checks++;
        if (period_last !== 24'd300 || gap_stb !== 1'b0 || tooth_stb !== 1'b1 || obs() !== expv())
        begin
            fails++; $display("FAIL post_reset: plast=%0d gap_stb=%b tstb=%b want 300 0 1",
                              period_last, gap_stb, tooth_stb);
        end
    endtask

    task automatic test_stall();
        int pulses, at;
        pulses = 0; at = 0;
        for (int i = 1; i <= 300; i++) begin
            s_step(0);
            if (s_stall === 1'b1) begin pulses++; at = i; end
        end
        checks++;
        if (pulses !== 1 || at !== 255) begin
            fails++; $display("FAIL stall_pulse: count=%0d cycle=%0d want 1 255", pulses, at);
        end
        checks++;
        if (s_sync !== 1'b0) begin
            fails++; $display("FAIL stall_sync: sync=%b want 0", s_sync);
        end
        s_step(1);
        checks++;
        if (s_period_last !== 8'd255 || s_gap_stb !== 1'b0 || s_tooth_stb !== 1'b1) begin
            fails++; $display("FAIL stall_edge: plast=%0d gap_stb=%b tstb=%b want 255 0 1",
                              s_period_last, s_gap_stb, s_tooth_stb);
        end
        for (int i = 1; i < 100; i++) s_step(0);
        s_step(1);
        checks++;
        if (s_period_last !== 8'd100 || s_gap_stb !== 1'b0) begin
            fails++; $display("FAIL stall_next: plast=%0d gap_stb=%b want 100 0", s_period_last,
                              s_gap_stb);
        end
        for (int i = 1; i < 250; i++) s_step(0);
        s_step(1);
        checks++;
        if (s_period_last !== 8'd250 || s_gap_stb !== 1'b1) begin
            fails++; $display("FAIL stall_gap: plast=%0d gap_stb=%b want 250 1", s_period_last,
                              s_gap_stb);
        end
        s_ena = 0;
    endtask

    task automatic test_random();
        int pos, base, cyc, r;
        bit want_gap;
        pos = 0; base = 30;
        for (int k = 0; k < 250; k++) begin
            if (pos == 0) base = 30 + int'($urandom_range(0, 4));
            want_gap = (pos == TEETH - 1);
            r = int'($urandom_range(0, 99));
            if (r == 0) want_gap = !want_gap;
            cyc = want_gap ? 3 * base : base + int'($urandom_range(0, 2));
            for (int c = 1; c <= cyc; c++) begin
                step($urandom_range(0, 7) != 0, c == cyc, (r == 50) && (c == cyc / 2));
                checks++;
                if (obs() !== expv()) begin
                    fails++; $display("FAIL random_t%0d_c%0d: got %h want %h", k, c, obs(), expv());
                end
            end
            pos = (want_gap || pos == TEETH - 1) ? 0 : pos + 1;
        end
    endtask

    initial begin
        test_reset();
        test_sync_acquire();
        test_early_gap();
        test_gap_boundary();
        test_missing_gap();
        test_resync();
        test_async_reset();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
